// File: rtl/rca_arbiter_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
package rca_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Index width for n items; never below one bit so single-entry ports stay legal.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational ripple-carry adder/subtractor; add_sub_b = 1 selects in1 - in2.
module ripple_carry_adder #(
    parameter int unsigned BUS_WIDTH = 32
) (
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    input  logic                 add_sub_b,
    output logic [BUS_WIDTH-1:0] sum
);

    always_comb begin : ripple
        logic w_c;
        logic w_b;
        sum = '0;
        // Subtraction as in1 + ~in2 + 1: the invert and the carry-in share add_sub_b.
        w_c = add_sub_b;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            w_b    = in2[i] ^ add_sub_b;
            sum[i] = in1[i] ^ w_b ^ w_c;
            w_c    = (in1[i] & w_b) | (w_c & (in1[i] ^ w_b));
        end
    end

endmodule

// File: rtl/rca_arbiter.sv
// Round-robin arbiter sharing one ripple_carry_adder among NUM_REQ requesters.
// Optional RCA_ARB_OVF_EN adds a registered two's-complement overflow flag rsp_ovf.
module rca_arbiter
    import rca_arbiter_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = 32,
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    localparam int unsigned ID_W         = id_w(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_add_sub_b,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_in1,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_in2,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [BUS_WIDTH-1:0]           rsp_out,
    output logic [ID_W-1:0]                rsp_id
`ifdef RCA_ARB_OVF_EN
    ,
    output logic                           rsp_ovf
`endif
);

    localparam int unsigned CNT_W          = id_w(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_REQ - 1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [ID_W-1:0]        r_ptr;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_op;
    logic [BUS_WIDTH-1:0]   r_in1;
    logic [BUS_WIDTH-1:0]   r_in2;
    logic [ID_W-1:0]        r_owner;
    logic                   r_rsp_valid;
    logic [BUS_WIDTH-1:0]   r_rsp_out;
    logic [ID_W-1:0]        r_rsp_id;

    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_win_id;
    logic                   w_win_op;
    logic [BUS_WIDTH-1:0]   w_win_in1;
    logic [BUS_WIDTH-1:0]   w_win_in2;
    logic [BUS_WIDTH-1:0]   w_sum;
    logic                   w_accept;
    logic                   w_sample;

    // First valid requester at or after ptr, ascending with wrap.
    function automatic logic [NUM_REQ-1:0] rr_grant(input logic [NUM_REQ-1:0] valid,
                                                    input logic [ID_W-1:0]    ptr);
        logic [NUM_REQ-1:0] g;
        logic               found;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && valid[j] && (((32'(ptr) + i) % NUM_REQ) == j)) begin
                    g[j]  = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

    assign w_grant = rr_grant(req_valid, r_ptr);

    always_comb begin
        w_win_id  = '0;
        w_win_op  = 1'b0;
        w_win_in1 = '0;
        w_win_in2 = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_id  = ID_W'(i);
                w_win_op  = req_add_sub_b[i];
                w_win_in1 = req_in1[i*BUS_WIDTH +: BUS_WIDTH];
                w_win_in2 = req_in2[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // Gated by rst_n so no grant is offered while reset is held.
    assign req_ready = (r_state == IDLE && rst_n) ? w_grant : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_state_nxt = EXEC;
                    w_accept    = 1'b1;
                end
            end
            EXEC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = RESP;
                    w_sample    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    ripple_carry_adder #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_adder (
        .in1       (r_in1),
        .in2       (r_in2),
        .add_sub_b (r_op),
        .sum       (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_op        <= OP_ADD;
            r_in1       <= '0;
            r_in2       <= '0;
            r_owner     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_out   <= '0;
            r_rsp_id    <= '0;
        end else begin
            if (r_state == EXEC) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_op    <= w_win_op;
                r_in1   <= w_win_in1;
                r_in2   <= w_win_in2;
                r_owner <= w_win_id;
                r_ptr   <= (w_win_id == ID_LAST) ? '0 : w_win_id + 1'b1;
                r_cnt   <= '0;
            end
            if (w_sample) begin
                r_rsp_out   <= w_sum;
                r_rsp_id    <= r_owner;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_out   = r_rsp_out;
    assign rsp_id    = r_rsp_id;

`ifdef RCA_ARB_OVF_EN
    logic r_rsp_ovf;
    logic w_ovf;

    always_comb begin
        if (r_op == OP_SUB) begin
            w_ovf = (r_in1[BUS_WIDTH-1] != r_in2[BUS_WIDTH-1]) &&
                    (w_sum[BUS_WIDTH-1] != r_in1[BUS_WIDTH-1]);
        end else begin
            w_ovf = (r_in1[BUS_WIDTH-1] == r_in2[BUS_WIDTH-1]) &&
                    (w_sum[BUS_WIDTH-1] != r_in1[BUS_WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_ovf <= 1'b0;
        end else if (w_sample) begin
            r_rsp_ovf <= w_ovf;
        end
    end

    assign rsp_ovf = r_rsp_ovf;
`endif

endmodule

// File: tb/tb_rca_arbiter.sv
// Directed, table-driven bench for rca_arbiter (BUS_WIDTH 32, NUM_REQ 4, SETTLE_CYCLES 2).
module tb_rca_arbiter;

    localparam int unsigned BW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned SC = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_add_sub_b;
    logic [NR*BW-1:0]   req_in1;
    logic [NR*BW-1:0]   req_in2;
    logic [NR-1:0]      req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [BW-1:0]      rsp_out;
    logic [1:0]         rsp_id;
`ifdef RCA_ARB_OVF_EN
    logic               rsp_ovf;
`endif

    rca_arbiter #(
        .BUS_WIDTH     (BW),
        .NUM_REQ       (NR),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_add_sub_b (req_add_sub_b),
        .req_in1       (req_in1),
        .req_in2       (req_in2),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_out       (rsp_out),
        .rsp_id        (rsp_id)
`ifdef RCA_ARB_OVF_EN
        ,
        .rsp_ovf       (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_slot(input int r, input logic op, input logic [31:0] a,
                            input logic [31:0] b);
        req_add_sub_b[r]    = op;
        req_in1[r*BW +: BW] = a;
        req_in2[r*BW +: BW] = b;
    endtask

    // Called at posedge+1; returns edges waited until rsp_valid, capped.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_after_accept", 64'(rsp_valid), 64'(0));
    endtask

    typedef struct {
        int          id;
        logic        op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] exp_out;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          lat;
        int          ng;
        int          nr;
        int          multi;
        int          gseq[6];
        int          rid[6];
        logic [31:0] rout[6];
        int          exp_order[6];
        logic [3:0]  one;

        vecs[0] = '{0, 1'b0, 32'd12,         32'd24, 32'd36,         1'b0};
        vecs[1] = '{2, 1'b1, 32'd110,        32'd24, 32'd86,         1'b0};
        vecs[2] = '{1, 1'b1, 32'd0,          32'd1,  32'hFFFF_FFFF,  1'b0};
        vecs[3] = '{3, 1'b0, 32'hFFFF_FFFF,  32'd2,  32'd1,          1'b0};
        vecs[4] = '{1, 1'b0, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000,  1'b1};
        vecs[5] = '{2, 1'b1, 32'h8000_0000,  32'd1,  32'h7FFF_FFFF,  1'b1};
        vecs[6] = '{0, 1'b0, 32'd5,          32'd3,  32'd8,          1'b0};
        vecs[7] = '{3, 1'b1, 32'd5,          32'd7,  32'hFFFF_FFFE,  1'b0};
        vecs[8] = '{0, 1'b1, 32'h8000_0000,  32'h8000_0000, 32'd0,   1'b0};
        exp_order = '{0, 1, 3, 0, 1, 3};
        one = 4'b0001;

        // Reset state, with requests already pending.
        rst_n         = 1'b0;
        req_valid     = 4'b1111;
        req_add_sub_b = '0;
        req_in1       = '0;
        req_in2       = '0;
        rsp_ready     = 1'b0;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_out",   64'(rsp_out),   64'(0));
        chk("reset_rsp_id",    64'(rsp_id),    64'(0));
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention: 0,1,3 held; expect grants 0,1,3,0,1,3.
        for (int i = 0; i < 4; i++) set_slot(i, 1'b0, 32'(100 + i), 32'(i));
        req_valid = 4'b1011;
        rsp_ready = 1'b1;
        ng = 0; nr = 0; multi = 0;
        for (int c = 0; c < 200 && nr < 6; c++) begin
            #1;
            if ($countones(req_ready) > 1) multi++;
            if (req_ready != '0 && ng < 6) begin
                for (int j = 0; j < 4; j++) if (req_ready[j]) gseq[ng] = j;
                ng++;
            end
            if (rsp_valid && nr < 6) begin
                rid[nr]  = int'(rsp_id);
                rout[nr] = rsp_out;
                nr++;
            end
            if (nr == 6) req_valid = '0;
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;
        chk("cont_grant_count", 64'(ng), 64'(6));
        chk("cont_rsp_count",   64'(nr), 64'(6));
        chk("cont_onehot",      64'(multi), 64'(0));
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("cont_grant%0d", k), 64'(gseq[k]), 64'(exp_order[k]));
            chk($sformatf("cont_id%0d", k),    64'(rid[k]),  64'(exp_order[k]));
            chk($sformatf("cont_out%0d", k),   64'(rout[k]), 64'(100 + 2 * exp_order[k]));
        end
        @(posedge clk);
        #1;

        // Table of single transactions.
        for (int v = 0; v < 9; v++) begin
            set_slot(vecs[v].id, vecs[v].op, vecs[v].in1, vecs[v].in2);
            req_valid = one << vecs[v].id;
            #1;
            chk($sformatf("v%0d_ready", v), 64'(req_ready), 64'(one << vecs[v].id));
            @(posedge clk);
            #1;
            req_valid = '0;
            chk($sformatf("v%0d_ready_exec", v), 64'(req_ready), 64'(0));
            wait_rsp(lat);
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'(SC));
            chk($sformatf("v%0d_out", v), 64'(rsp_out), 64'(vecs[v].exp_out));
            chk($sformatf("v%0d_id", v), 64'(rsp_id), 64'(vecs[v].id));
`ifdef RCA_ARB_OVF_EN
            chk($sformatf("v%0d_ovf", v), 64'(rsp_ovf), 64'(vecs[v].exp_ovf));
`endif
            accept_rsp();
        end

        // Backpressure with a competing request waiting.
        set_slot(1, 1'b0, 32'd100, 32'd200);
        set_slot(2, 1'b1, 32'd7, 32'd2);
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        req_valid = 4'b0100;
        wait_rsp(lat);
        chk("bp_latency", 64'(lat), 64'(SC));
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid%0d", k), 64'(rsp_valid), 64'(1));
            chk($sformatf("bp_out%0d", k),   64'(rsp_out),   64'(300));
            chk($sformatf("bp_id%0d", k),    64'(rsp_id),    64'(1));
            chk($sformatf("bp_ready%0d", k), 64'(req_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        accept_rsp();
        #1;
        chk("bp_next_grant", 64'(req_ready), 64'(4'b0100));
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp(lat);
        chk("bp2_out", 64'(rsp_out), 64'(5));
        chk("bp2_id",  64'(rsp_id),  64'(2));
        accept_rsp();

        // Asynchronous reset during EXEC; pointer must return to 0.
        set_slot(3, 1'b0, 32'd9, 32'd9);
        set_slot(0, 1'b0, 32'd40, 32'd2);
        req_valid = 4'b1000;
        @(posedge clk);
        #1;
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_exec_valid", 64'(rsp_valid), 64'(0));
        chk("rst_exec_out",   64'(rsp_out),   64'(0));
        chk("rst_exec_id",    64'(rsp_id),    64'(0));
        req_valid = 4'b1111;
        #1;
        chk("rst_exec_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_first_grant", 64'(req_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp(lat);
        chk("rst_post_latency", 64'(lat), 64'(SC));
        chk("rst_post_out", 64'(rsp_out), 64'(42));
        chk("rst_post_id",  64'(rsp_id),  64'(0));
        accept_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rca_arbiter.md
Name: rca_arbiter

Overview:
Round-robin arbiter and sequencer that shares one ripple_carry_adder instance among NUM_REQ requesters. It grants one add/sub request at a time and registers the operands. It then holds them stable for a programmable number of settle cycles to cover the ripple path. Finally it registers the sum/difference and returns it with the requester ID over a valid/ready response port.

Parameters:
BUS_WIDTH, 32, operand/result width; passed to ripple_carry_adder.
NUM_REQ, 4, number of requesters (2..16).
SETTLE_CYCLES, 2, cycles operands are held on the adder before sampling out (>=1).

Ports:
clk  input  1  clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_add_sub_b  input  NUM_REQ  per-requester op: 0 = in1+in2, 1 = in1-in2.
req_in1  input  NUM_REQ*BUS_WIDTH  packed first operands; requester i at [i*BUS_WIDTH +: BUS_WIDTH].
req_in2  input  NUM_REQ*BUS_WIDTH  packed second operands, same packing.
req_ready  output  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] && req_ready[i].
rsp_valid  output  1  result valid.
rsp_ready  input  1  consumer accepts result.
rsp_out  output  BUS_WIDTH  registered adder result.
rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns rsp_out.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; rr pointer = 0; settle counter = 0.
  - rsp_valid = 0; rsp_out = 0; rsp_id = 0; req_ready = 0.
  - Operand registers = 0.
  - Any in-flight operation is discarded. Reset is legal in any state.
- States:
  - IDLE:
    - req_ready = one-hot grant, combinational from req_valid and the rr pointer.
    - The search starts at the pointer index, ascending, wrapping modulo NUM_REQ.
    - If any req_valid is set: capture add_sub_b/in1/in2 and the winner ID into registers; pointer <= (winner+1) mod NUM_REQ; counter <= 0; go to EXEC.
    - If no request: stay in IDLE; req_ready = 0.
  - EXEC:
    - req_ready = 0. Registered operands drive the adder; counter increments each cycle.
    - In the cycle where counter == SETTLE_CYCLES-1: rsp_out <= adder out; rsp_id <= owner; rsp_valid <= 1; go to RESP.
  - RESP:
    - rsp_valid = 1; rsp_out and rsp_id are held stable.
    - On rsp_valid && rsp_ready: rsp_valid <= 0, go to IDLE.
    - Otherwise hold indefinitely (backpressure).
- Latency:
  - Handshake edge T; rsp_valid is high from edge T+SETTLE_CYCLES.
  - Next grant is earliest in the cycle after response acceptance.
  - Throughput is one operation per SETTLE_CYCLES+2 cycles minimum.
- Handshake rules:
  - Requesters keep valid and data stable until accepted; the arbiter never drops an asserted request.
  - At most one req_ready bit is set at any time. req_ready never asserts outside IDLE.
  - Deasserting req_valid before grant is permitted and simply removes the request from arbitration.
- Arithmetic:
  - Modulo 2^BUS_WIDTH; wrap-around is silent (e.g. 0 - 1 = all ones). No carry-out port.
- Simultaneous requests:
  - Resolved only by the rr pointer. Each requester waits at most NUM_REQ-1 grants.
- rsp_ready high while not in RESP: ignored.
- SETTLE_CYCLES = 1: EXEC lasts exactly one cycle.

Optional Feature:
RCA_ARB_OVF_EN
- Defined:
  - Adds output rsp_ovf (1 bit), registered with rsp_out and reset to 0.
  - Set when the operation overflows as two's complement.
  - Add: in1 and in2 have equal sign bits and the result sign differs.
  - Sub: in1 and in2 sign bits differ and the result sign differs from in1.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package rca_arbiter_pkg holds:
  - state enum {IDLE, EXEC, RESP} with 2-bit encoding;
  - ID_W = $clog2(NUM_REQ) helper function;
  - the op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
- One sub-module: the existing ripple_carry_adder, instantiated once with BUS_WIDTH.
- The round-robin grant is a function inside the block, not a separate module.

Test Plan:
- Single add, SETTLE_CYCLES = 2:
  - Stimulus: req_valid = 0001, op = 0, in1 = 12, in2 = 24.
  - Response: req_ready = 0001 for one cycle; rsp_valid high 2 cycles after the grant edge; rsp_out = 36; rsp_id = 0.
- Subtract on requester 2:
  - Stimulus: op = 1, in1 = 110, in2 = 24.
  - Response: rsp_out = 86; rsp_id = 2.
- Contention:
  - Stimulus: req_valid = 1011 held continuously, rsp_ready = 1.
  - Response: grant order 0, 1, 3, 0, 1, 3; never two req_ready bits at once.
- Backpressure:
  - Stimulus: rsp_ready = 0 for 5 cycles after rsp_valid.
  - Response: rsp_out and rsp_id stable; req_ready = 0 throughout; acceptance occurs on the first rsp_ready = 1 cycle.
- Reset mid-EXEC:
  - Stimulus: rst_n low asynchronously during EXEC.
  - Response: rsp_valid = 0, rsp_out = 0, req_ready = 0 immediately; after release the first grant goes to requester 0.
- Wrap and overflow:
  - Stimulus: in1 = 0, in2 = 1, sub.
  - Response: rsp_out = 0xFFFFFFFF.
  - With RCA_ARB_OVF_EN: 0x7FFFFFFF + 1 gives rsp_ovf = 1; 0x80000000 - 1 gives rsp_ovf = 1; 5 + 3 gives rsp_ovf = 0.
